// File: rtl/keccak_pkg.sv
// Shared constants, rho offset table and FSM encoding for the Keccak
// slice-oriented permutation stages.
package keccak_pkg;

    localparam int LINE_W = 25;  // bits per slice, bit 5*y+x
    localparam int LANE_W = 64;  // slices per frame (lane length)
    localparam int CNT_W  = 6;   // slice counter width

    // Rho rotation offsets, indexed [x][y].
    localparam logic [CNT_W-1:0] RHO_OFS [5][5] = '{
        '{6'd0,  6'd36, 6'd3,  6'd41, 6'd18},
        '{6'd1,  6'd44, 6'd10, 6'd45, 6'd2 },
        '{6'd62, 6'd6,  6'd43, 6'd15, 6'd61},
        '{6'd28, 6'd55, 6'd25, 6'd21, 6'd56},
        '{6'd27, 6'd20, 6'd39, 6'd8,  6'd14}
    };

    // Position of lane (x,y) inside a slice.
    function automatic int bit_idx(input int x, input int y);
        return 5 * y + x;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } rho_state_t;

endpackage

// File: rtl/rho_slice_sel.sv
// Combinational rho slice builder: each lane bit of output slice rd_cnt is
// taken from the buffered slice (rd_cnt - R[x][y]) mod 64, which is a rotate
// of the lane toward higher z by R.
module rho_slice_sel
    import keccak_pkg::*;
(
    input  logic [LANE_W-1:0][LINE_W-1:0] slices,
    input  logic [CNT_W-1:0]              rd_cnt,
    output logic [LINE_W-1:0]             rot_slice
);

    // 25 independent 64:1 selects; the 6-bit subtraction gives the mod-64 wrap.
    for (genvar x = 0; x < 5; x++) begin : g_x
        for (genvar y = 0; y < 5; y++) begin : g_y
            localparam int BI = bit_idx(x, y);
            logic [CNT_W-1:0] src;
            assign src           = rd_cnt - RHO_OFS[x][y];
            assign rot_slice[BI] = slices[src][BI];
        end
    end

endmodule

// File: rtl/rho_func.sv
// Keccak rho stage: collects a full 64-slice frame from theta, then streams
// out the lane-rotated slices over valid/ready and pulses done per frame.
module rho_func
    import keccak_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [LINE_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LINE_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_idx,
    output logic              done
);

    rho_state_t                    state, state_nxt;
    logic [CNT_W-1:0]              wr_cnt, rd_cnt;
    logic [LANE_W-1:0][LINE_W-1:0] slice_buf;
    logic [LINE_W-1:0]             rot_slice;
    logic                          accept, emit;

    assign accept = in_valid & in_ready;
    assign emit   = out_valid & out_ready;

    // State register and slice counters; counters wrap naturally at 64.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept) wr_cnt <= wr_cnt + 1'b1;
            if (emit)   rd_cnt <= rd_cnt + 1'b1;
        end
    end

    // Frame buffer; contents are don't-care after reset so it is not cleared.
    always_ff @(posedge clk) begin
        if (accept) slice_buf[wr_cnt] <= in_data;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (accept) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                if (accept && wr_cnt == CNT_W'(LANE_W - 1)) state_nxt = ST_EMIT;
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                if (emit && rd_cnt == CNT_W'(LANE_W - 1)) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    rho_slice_sel u_sel (
        .slices    (slice_buf),
        .rd_cnt    (rd_cnt),
        .rot_slice (rot_slice)
    );

    // Output slice is only driven while emitting so idle output reads zero.
    assign out_data = out_valid ? rot_slice : '0;
    assign out_idx  = rd_cnt;

endmodule
